best_arr_out_sched: RTL and testbench

Streams the best-match index array from the on-chip best-array memory to the output FIFO once the main algorithm finishes. It walks queries in the blocked output order: half-image, column block, row, lane within block, skipping lanes that fall past the half-row width. It issues single-cycle-latency memory reads and absorbs output-FIFO backpressure with a 2-entry buffer. It sits between the top-level FSM (`send_best_arr` pulse) and the output FIFO's write side.

---
 rtl/best_arr_out_pkg.sv | 20 ++
 rtl/best_arr_out_buf.sv | 42 ++++
 rtl/best_arr_out_sched.sv | 151 +++++++++++++++
 tb/tb_best_arr_out_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/best_arr_out_pkg.sv
// Shared types and derived geometry for the best-array output scheduler.
// The helpers map the image row width to the half-row width and the column block count.
package best_arr_out_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int HALF(input int row_size);
        return row_size / 2;
    endfunction

    function automatic int NBLK(input int row_size, input int blocking);
        return (row_size / 2 + blocking - 1) / blocking;
    endfunction

endpackage

// File: rtl/best_arr_out_buf.sv
// Two-entry FIFO that absorbs output backpressure.
// The caller must never write when the FIFO is full or pop when it is empty.
module best_arr_out_buf #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_wr) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(i_wr) - 2'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/best_arr_out_sched.sv
// Streams the best-index array to the output FIFO in blocked order
// (half-image, column block, row, lane) under a two-credit read window.
module best_arr_out_sched
    import best_arr_out_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int IDX_WIDTH  = 9,
    parameter int ROW_SIZE   = 26,
    parameter int COL_SIZE   = 19,
    parameter int BLOCKING   = 4,
    parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
    parameter int ADDR_WIDTH = $clog2(NUM_QUERYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [IDX_WIDTH-1:0]  mem_rd_data,
    output logic                  out_fifo_wenq,
    output logic [DATA_WIDTH-1:0] out_fifo_wdata,
    input  logic                  out_fifo_wfull_n
);

    localparam int HALF_C = HALF(ROW_SIZE);
    localparam int NBLK_C = NBLK(ROW_SIZE, BLOCKING);
    localparam int YW     = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
    localparam int XW     = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;

    localparam logic [ADDR_WIDTH-1:0] L_HALF     = ADDR_WIDTH'(HALF_C);
    localparam logic [ADDR_WIDTH-1:0] L_ROW      = ADDR_WIDTH'(ROW_SIZE);
    localparam logic [ADDR_WIDTH-1:0] L_BLK      = ADDR_WIDTH'(BLOCKING);
    localparam logic [ADDR_WIDTH-1:0] L_LAST_COL = ADDR_WIDTH'((NBLK_C - 1) * BLOCKING);
    localparam logic [YW-1:0]         L_Y_LAST   = YW'(COL_SIZE - 1);
    localparam logic [XW-1:0]         L_XI_LAST  = XW'(BLOCKING - 1);

    state_t                r_state;
    state_t                w_next;
    logic                  r_px;
    logic [ADDR_WIDTH-1:0] r_col;
    logic [ADDR_WIDTH-1:0] r_blk_base;
    logic [ADDR_WIDTH-1:0] r_row_base;
    logic [YW-1:0]         r_y;
    logic [XW-1:0]         r_xi;
    logic                  r_inflight;

    logic [IDX_WIDTH-1:0]  w_head;
    logic [1:0]            w_count;
    logic [2:0]            w_occ;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_lane_last;
    logic                  w_row_last;
    logic                  w_blk_last;
    logic                  w_last;

    // A lane ends its group at the block edge or where it would pass the half-row width,
    // so lanes beyond HALF are never visited.
    assign w_lane_last = (r_xi == L_XI_LAST) ||
                         ((r_col + ADDR_WIDTH'(r_xi) + ADDR_WIDTH'(1)) >= L_HALF);
    assign w_row_last  = (r_y == L_Y_LAST);
    assign w_blk_last  = (r_col == L_LAST_COL);
    assign w_last      = w_lane_last & w_row_last & w_blk_last & r_px;

    assign w_pop   = (w_count != 2'd0) & out_fifo_wfull_n;
    assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight};
    assign w_issue = (r_state == RUN) && ((w_occ - {2'b00, w_pop}) < 3'd2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_issue && w_last) w_next = DRAIN;
            DRAIN:   if (!r_inflight && (w_count == {1'b0, w_pop})) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Address = row base + lane; bases move by constant strides only.
    always_ff @(posedge clk) begin
        if (!rst_n || (r_state == IDLE)) begin
            r_px       <= 1'b0;
            r_col      <= '0;
            r_blk_base <= '0;
            r_row_base <= '0;
            r_y        <= '0;
            r_xi       <= '0;
        end else if (w_issue) begin
            if (!w_lane_last) begin
                r_xi <= r_xi + XW'(1);
            end else begin
                r_xi <= '0;
                if (!w_row_last) begin
                    r_y        <= r_y + YW'(1);
                    r_row_base <= r_row_base + L_ROW;
                end else begin
                    r_y <= '0;
                    if (!w_blk_last) begin
                        r_col      <= r_col + L_BLK;
                        r_blk_base <= r_blk_base + L_BLK;
                        r_row_base <= r_blk_base + L_BLK;
                    end else begin
                        r_col      <= '0;
                        r_px       <= 1'b1;
                        r_blk_base <= L_HALF;
                        r_row_base <= L_HALF;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
        end
    end

    best_arr_out_buf #(
        .W(IDX_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (r_inflight),
        .i_wdata (mem_rd_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign busy           = (r_state != IDLE);
    assign done           = (r_state == DONE);
    assign mem_rd_en      = w_issue;
    assign mem_rd_addr    = r_row_base + ADDR_WIDTH'(r_xi);
    assign out_fifo_wenq  = w_pop;
    assign out_fifo_wdata = DATA_WIDTH'(w_head);

endmodule

// File: tb/tb_best_arr_out_sched.sv
// Randomized bench for best_arr_out_sched against a loop-order reference model;
// a second instance covers a geometry with no partial column block.
module tb_best_arr_out_sched;

    localparam int NQ = 26 * 19;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start_b;
    logic        wfull_n;

    logic        busy_a, done_a, rd_en_a, wenq_a;
    logic [8:0]  rd_addr_a;
    logic [8:0]  rd_data_a;
    logic [10:0] wdata_a;

    logic        busy_b, done_b, rd_en_b, wenq_b;
    logic [5:0]  rd_addr_b;
    logic [8:0]  rd_data_b;
    logic [10:0] wdata_b;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int t0  = 0;
    int mode = 0;
    bit run_active = 1'b0;
    bit run_b = 1'b0;

    logic [10:0] ref_a[$];
    logic [10:0] ref_b[$];
    logic [10:0] exp_q[$];
    logic [10:0] addr_got[$];
    logic [10:0] got_b[$];

    int issued, enqd, done_cnt, done_b_cnt, first_rd, first_enq, last_enq, done_cyc, occ_viol;

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    best_arr_out_sched u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .busy             (busy_a),
        .done             (done_a),
        .mem_rd_en        (rd_en_a),
        .mem_rd_addr      (rd_addr_a),
        .mem_rd_data      (rd_data_a),
        .out_fifo_wenq    (wenq_a),
        .out_fifo_wdata   (wdata_a),
        .out_fifo_wfull_n (wfull_n)
    );

    best_arr_out_sched #(
        .ROW_SIZE (16),
        .COL_SIZE (3),
        .BLOCKING (4)
    ) u_dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start_b),
        .busy             (busy_b),
        .done             (done_b),
        .mem_rd_en        (rd_en_b),
        .mem_rd_addr      (rd_addr_b),
        .mem_rd_data      (rd_data_b),
        .out_fifo_wenq    (wenq_b),
        .out_fifo_wdata   (wdata_b),
        .out_fifo_wfull_n (1'b1)
    );

    // best-array memories preloaded with mem[a] = a, one-cycle read latency
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= rd_addr_a;
        if (rd_en_b) rd_data_b <= 9'(rd_addr_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // reference order straight from the loop nest and the address formula
    task automatic build_ref(input int row, input int col, input int blk, input int sel);
        int half, nblk;
        half = row / 2;
        nblk = (half + blk - 1) / blk;
        for (int px = 0; px < 2; px++)
            for (int x = 0; x < nblk; x++)
                for (int y = 0; y < col; y++)
                    for (int xi = 0; xi < blk; xi++)
                        if (x * blk + xi < half) begin
                            if (sel == 0) ref_a.push_back(11'(px * half + y * row + x * blk + xi));
                            else          ref_b.push_back(11'(px * half + y * row + x * blk + xi));
                        end
    endtask

    // output-FIFO back-pressure driver
    always @(posedge clk) begin
        int rel;
        #1;
        rel = cyc - t0;
        case (mode)
            1:       wfull_n = 1'($urandom_range(0, 1));
            2:       wfull_n = !(rel >= 5 && rel < 25);
            default: wfull_n = 1'b1;
        endcase
    end

    // scoreboard / monitor
    always @(negedge clk) begin
        int rel;
        rel = cyc - t0;
        if (run_active) begin
            if (rel == 1 && mode != 4) check("busy_c1", busy_a, 1);
            if (mode == 2 && rel == 24) begin
                check("stall_occ", issued - enqd, 2);
                check("stall_rd_en", rd_en_a, 0);
                check("stall_wenq", wenq_a, 0);
            end
            if (mode == 4 && rel == 51)
                check("midrun_rst_outs", {busy_a, done_a, rd_en_a, rd_addr_a, wenq_a, wdata_a}, 0);
            if (mode == 4 && rel == 55) check("idle_after_rst", busy_a, 0);
            if (rd_en_a && (issued - enqd - int'(wenq_a)) >= 2) occ_viol++;
            if (rd_en_a) begin
                addr_got.push_back(11'(rd_addr_a));
                if (first_rd < 0) first_rd = rel;
                issued++;
            end
            if (wenq_a) begin
                if (exp_q.size() == 0) check("extra_word", wdata_a, 32'hFFFF);
                else                   check("fifo_data", wdata_a, exp_q.pop_front());
                if (first_enq < 0) first_enq = rel;
                last_enq = rel;
                enqd++;
            end
            if (done_a) begin
                done_cnt++;
                done_cyc = rel;
            end
        end
        if (run_b) begin
            if (wenq_b) got_b.push_back(wdata_b);
            if (done_b) done_b_cnt++;
        end
    end

    task automatic run_a(input int m);
        int rel;
        mode = m;
        exp_q = ref_a;
        addr_got.delete();
        issued = 0; enqd = 0; done_cnt = 0; occ_viol = 0;
        first_rd = -1; first_enq = -1; last_enq = -1; done_cyc = -1;
        @(posedge clk); #1;
        start = 1'b1;
        if (m == 0 && !run_b) begin
            start_b = 1'b1;
            run_b = 1'b1;
        end
        t0 = cyc;
        run_active = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_b = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            rel = cyc - t0;
            if (m == 3) start = (rel == 100);
            if (m == 4) rst_n = !(rel == 50);
            if (m == 4 && rel > 60) break;
            if (done_cnt > 0) break;
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        start = 1'b0;
        if (m != 4) begin
            check("done_seen", (done_cnt > 0), 1);
            repeat (20) @(posedge clk);
            #1;
            check("done_once", done_cnt, 1);
            check("enq_count", enqd, NQ);
            check("scoreboard_empty", exp_q.size(), 0);
            check("occ_limit", occ_viol, 0);
            check("busy_after", busy_a, 0);
        end
        run_active = 1'b0;
        mode = 0;
    endtask

    task automatic check_addr_seq();
        int f0;
        check("addr_count", addr_got.size(), NQ);
        f0 = n_fail;
        for (int i = 0; i < addr_got.size() && i < ref_a.size(); i++) begin
            check("addr_seq", addr_got[i], ref_a[i]);
            if (n_fail != f0) break;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        start_b = 1'b0;
        wfull_n = 1'b1;
        build_ref(26, 19, 4, 0);
        build_ref(16, 3, 4, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {busy_a, done_a, rd_en_a, rd_addr_a, wenq_a, wdata_a}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // free-running output, plus the small-geometry instance
        run_a(0);
        check("first_rd_cycle", first_rd, 1);
        check("first_enq_cycle", first_enq, 3);
        check("last_enq_cycle", last_enq, NQ + 2);
        check("done_cycle", done_cyc, NQ + 3);
        check_addr_seq();
        check("addr_row1", addr_got[4], 26);
        check("addr_lane3_a", addr_got[228], 12);
        check("addr_lane3_b", addr_got[229], 38);
        check("addr_px1", addr_got[247], 13);
        check("addr_last", addr_got[NQ - 1], 493);

        check("b_count", got_b.size(), 48);
        check("b_done_once", done_b_cnt, 1);
        check("b_word4", got_b[4], 16);
        check("b_word5", got_b[5], 17);
        begin
            int f0;
            f0 = n_fail;
            for (int i = 0; i < got_b.size() && i < ref_b.size(); i++) begin
                check("b_seq", got_b[i], ref_b[i]);
                if (n_fail != f0) break;
            end
        end

        run_a(1);
        check_addr_seq();
        run_a(2);
        check_addr_seq();
        run_a(3);
        run_a(4);
        run_a(0);
        check("restart_first_addr", addr_got[0], 0);
        check_addr_seq();

        // start coinciding with reset is dropped
        @(posedge clk); #1;
        start = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_beats_start_busy", busy_a, 0);
        check("rst_beats_start_rd", rd_en_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
